contador_programa_pilha: RTL and testbench

Parametrised program counter with an internal return-address stack for call/return. Supports reset, absolute load, signed relative branch, call (push and jump), return (pop) and step increment. Sits at the front of the fetch path and drives the memory address. Generalises the fixed 16-bit reset/load/increment counter in width, step size and subroutine nesting.

---
 rtl/contador_programa_pilha.sv | 134 +++++++++++++
 tb/tb_contador_programa_pilha.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/contador_programa_pilha.sv
// Program counter with an internal return-address stack (call/return).
// One action per edge, chosen by fixed priority; all outputs come from registers.
module contador_programa_pilha #(
  parameter int LARGURA       = 16,
  parameter int PASSO         = 1,
  parameter int PROFUNDIDADE  = 8,
  parameter int VALOR_INICIAL = 0
) (
  input  logic                                relogio,
  input  logic                                reiniciar,
  input  logic [LARGURA-1:0]                  entrada,
  input  logic [LARGURA-1:0]                  deslocamento,
  input  logic                                carregar,
  input  logic                                chamar,
  input  logic                                retornar,
  input  logic                                saltar_rel,
  input  logic                                soma,
  output logic [LARGURA-1:0]                  resultado,
  output logic [$clog2(PROFUNDIDADE+1)-1:0]   nivel,
  output logic                                pilha_cheia,
  output logic                                pilha_vazia,
  output logic                                erro_estouro,
  output logic                                erro_vazio
);

  localparam int NW = $clog2(PROFUNDIDADE + 1);
  localparam int IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  localparam logic [LARGURA-1:0] PASSO_W   = LARGURA'(PASSO);
  localparam logic [LARGURA-1:0] INICIAL_W = LARGURA'(VALOR_INICIAL);
  localparam logic [NW-1:0]      NIVEL_MAX = NW'(PROFUNDIDADE);
  localparam logic [NW-1:0]      NIVEL_UM  = NW'(1);

  typedef enum logic [2:0] {
    ACAO_NADA,
    ACAO_CARREGAR,
    ACAO_CHAMAR,
    ACAO_RETORNAR,
    ACAO_SALTAR,
    ACAO_SOMA
  } acao_t;

  logic [LARGURA-1:0] resultado_q, resultado_d;
  logic [NW-1:0]      nivel_q, nivel_d;
  logic               estouro_q, estouro_d;
  logic               vazio_q, vazio_d;

  logic [LARGURA-1:0] pilha_q [PROFUNDIDADE];

  acao_t              acao;
  logic               cheia, vazia;
  logic               push_en;
  logic [IW-1:0]      push_idx, pop_idx;
  logic [LARGURA-1:0] push_dado;

  assign cheia = (nivel_q == NIVEL_MAX);
  assign vazia = (nivel_q == '0);

  // Priority decode: only the highest-priority request survives.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    acao = ACAO_NADA;
    if (carregar)        acao = ACAO_CARREGAR;
    else if (chamar)     acao = ACAO_CHAMAR;
    else if (retornar)   acao = ACAO_RETORNAR;
    else if (saltar_rel) acao = ACAO_SALTAR;
    else if (soma)       acao = ACAO_SOMA;
  end

  always_comb begin
    resultado_d = resultado_q;
    nivel_d     = nivel_q;
    estouro_d   = estouro_q;
    vazio_d     = vazio_q;
    push_en     = 1'b0;
    push_idx    = IW'(nivel_q);
    pop_idx     = IW'(nivel_q - NIVEL_UM);
    push_dado   = resultado_q + PASSO_W;

    unique case (acao)
      ACAO_CARREGAR: resultado_d = entrada;
      ACAO_CHAMAR: begin
        if (cheia) begin
          estouro_d = 1'b1;
        end else begin
          push_en     = !reiniciar;
          nivel_d     = nivel_q + NIVEL_UM;
          resultado_d = entrada;
        end
      end
      ACAO_RETORNAR: begin
        if (vazia) begin
          vazio_d = 1'b1;
        end else begin
          nivel_d     = nivel_q - NIVEL_UM;
          resultado_d = pilha_q[pop_idx];
        end
      end
      ACAO_SALTAR:   resultado_d = resultado_q + deslocamento;
      ACAO_SOMA:     resultado_d = resultado_q + PASSO_W;
      default:       ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge relogio) begin
    if (reiniciar) begin
      resultado_q <= INICIAL_W;
      nivel_q     <= '0;
      estouro_q   <= 1'b0;
      vazio_q     <= 1'b0;
    end else begin
      resultado_q <= resultado_d;
      nivel_q     <= nivel_d;
      estouro_q   <= estouro_d;
      vazio_q     <= vazio_d;
    end
  end

  // NOTE: the stack array has no reset; entries above nivel are never read, so clearing them buys nothing.
  always_ff @(posedge relogio) begin
    if (push_en) begin
      pilha_q[push_idx] <= push_dado;
    end
  end

  assign resultado    = resultado_q;
  assign nivel        = nivel_q;
  assign pilha_cheia  = cheia;
  assign pilha_vazia  = vazia;
  assign erro_estouro = estouro_q;
  assign erro_vazio   = vazio_q;

endmodule

// File: tb/tb_contador_programa_pilha.sv
// Directed bench for contador_programa_pilha: a reference model pushes expected
// state into a scoreboard queue each step; it is popped and compared after the edge.
module tb_contador_programa_pilha;

  localparam int W = 16;
  localparam int P = 8;
  localparam int NW = $clog2(P + 1);

  logic          relogio = 1'b0;
  logic          reiniciar, carregar, chamar, retornar, saltar_rel, soma;
  logic [W-1:0]  entrada, deslocamento;
  logic [W-1:0]  resultado;
  logic [NW-1:0] nivel;
  logic          pilha_cheia, pilha_vazia, erro_estouro, erro_vazio;

  contador_programa_pilha #(
    .LARGURA(W), .PASSO(1), .PROFUNDIDADE(P), .VALOR_INICIAL(0)
  ) dut (
    .relogio(relogio), .reiniciar(reiniciar), .entrada(entrada),
    .deslocamento(deslocamento), .carregar(carregar), .chamar(chamar),
    .retornar(retornar), .saltar_rel(saltar_rel), .soma(soma),
    .resultado(resultado), .nivel(nivel), .pilha_cheia(pilha_cheia),
    .pilha_vazia(pilha_vazia), .erro_estouro(erro_estouro), .erro_vazio(erro_vazio)
  );

  always #5 relogio = ~relogio;

  typedef struct {
    string        tag;
    logic [W-1:0] pc;
    int           nivel;
    logic         cheia, vazia, eo, ev;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  logic         m_eo, m_ev;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of one edge, written from the behavioural description.
  task automatic model(input logic r, input logic c, input logic ch, input logic rt,
                       input logic sr, input logic sm, input logic [W-1:0] ent,
                       input logic [W-1:0] des);
    if (r) begin
      m_pc = '0; m_stk.delete(); m_eo = 0; m_ev = 0;
    end else if (c) begin
      m_pc = ent;
    end else if (ch) begin
      if (m_stk.size() < P) begin
        m_stk.push_back(W'(m_pc + 1));
        m_pc = ent;
      end else m_eo = 1;
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_ev = 1;
    end else if (sr) begin
      m_pc = W'(m_pc + des);
    end else if (sm) begin
      m_pc = W'(m_pc + 1);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic c, input logic ch,
                      input logic rt, input logic sr, input logic sm,
                      input logic [W-1:0] ent, input logic [W-1:0] des);
    exp_t e, got;
    reiniciar = r; carregar = c; chamar = ch; retornar = rt;
    saltar_rel = sr; soma = sm; entrada = ent; deslocamento = des;
    model(r, c, ch, rt, sr, sm, ent, des);
    e.tag = tag; e.pc = m_pc; e.nivel = m_stk.size();
    e.cheia = (m_stk.size() == P); e.vazia = (m_stk.size() == 0);
    e.eo = m_eo; e.ev = m_ev;
    sb.push_back(e);
    @(posedge relogio);
    #1;
    reiniciar = 0; carregar = 0; chamar = 0; retornar = 0; saltar_rel = 0; soma = 0;
    got = sb.pop_front();
    check({got.tag, ".pc"}, 32'(resultado), 32'(got.pc));
    check({got.tag, ".nivel"}, 32'(nivel), 32'(got.nivel));
    check({got.tag, ".cheia"}, 32'(pilha_cheia), 32'(got.cheia));
    check({got.tag, ".vazia"}, 32'(pilha_vazia), 32'(got.vazia));
    check({got.tag, ".eo"}, 32'(erro_estouro), 32'(got.eo));
    check({got.tag, ".ev"}, 32'(erro_vazio), 32'(got.ev));
  endtask

  initial begin
    reiniciar = 1; carregar = 0; chamar = 0; retornar = 0; saltar_rel = 0; soma = 0;
    entrada = '0; deslocamento = '0;
    m_pc = '0; m_eo = 0; m_ev = 0;
    #2;

    // Reset and step
    step("reset", 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    check("reset_pc_const", 32'(resultado), 32'h0);
    step("soma1", 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    step("soma2", 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    step("soma3", 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    check("soma3_const", 32'(resultado), 32'h3);
    step("hold", 0, 0, 0, 0, 0, 0, 16'h1234, 16'h0000);

    // Wrap and relative branch
    step("load_fffe", 0, 1, 0, 0, 0, 0, 16'hFFFE, 16'h0000);
    step("wrap1", 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    step("wrap2", 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    check("wrap_const", 32'(resultado), 32'h0000);
    step("load_0010", 0, 1, 0, 0, 0, 0, 16'h0010, 16'h0000);
    step("rel_neg", 0, 0, 0, 0, 1, 0, 16'h0000, 16'hFFFC);
    check("rel_neg_const", 32'(resultado), 32'h000C);
    step("rel_over_soma", 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0020);

    // Nested call/return
    step("load_0100", 0, 1, 0, 0, 0, 0, 16'h0100, 16'h0000);
    step("call_0200", 0, 0, 1, 0, 0, 0, 16'h0200, 16'h0000);
    step("call_0300", 0, 0, 1, 0, 0, 0, 16'h0300, 16'h0000);
    step("ret1", 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    check("ret1_const", 32'(resultado), 32'h0201);
    step("ret2", 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    check("ret2_const", 32'(resultado), 32'h0101);

    // Overflow then underflow
    for (int i = 0; i < P; i++)
      step($sformatf("fill%0d", i), 0, 0, 1, 0, 0, 0, W'(16'h1000 + i), 16'h0000);
    check("full_const", 32'(pilha_cheia), 32'h1);
    step("call_full", 0, 0, 1, 0, 0, 0, 16'h2000, 16'h0000);
    check("call_full_pc_const", 32'(resultado), 32'h1007);
    step("soma_after_eo", 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    for (int i = 0; i < P; i++)
      step($sformatf("drain%0d", i), 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    step("ret_empty", 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    check("ret_empty_ev_const", 32'(erro_vazio), 32'h1);
    step("flags_persist", 0, 1, 0, 0, 0, 0, 16'h0777, 16'h0000);

    // Priority
    step("reset2", 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    step("load_call_soma", 0, 1, 1, 0, 0, 1, 16'h0040, 16'h0000);
    check("lcs_nivel_const", 32'(nivel), 32'h0);
    step("call_0500", 0, 0, 1, 0, 0, 0, 16'h0500, 16'h0000);
    step("call_and_ret", 0, 0, 1, 1, 0, 0, 16'h0600, 16'h0000);
    check("car_nivel_const", 32'(nivel), 32'h2);

    // Reset mid-operation
    step("call3", 0, 0, 1, 0, 0, 0, 16'h0700, 16'h0000);
    step("reset_with_call", 1, 0, 1, 0, 0, 0, 16'h0900, 16'h0000);
    step("ret_after_reset", 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    check("ret_after_reset_const", 32'(erro_vazio), 32'h1);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
